// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS32-subset CPU with a minimal CP0 (one external interrupt, precise exceptions).
// Optional AdEL/AdES address exceptions are enabled by defining MIPS_CPU_ADDR_EXC_EN.
module mips_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    logic [31:0] pc_r;
    logic [31:0] epc_r;
    logic [31:0] grf_r [32];
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic [4:0]  exc_code_r;

    logic [5:0]  op_s, funct_s, ip_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wa_s, exc_code_s;
    logic [31:0] rs_val_s, rt_val_s, imm_sext_s, imm_zext_s, pc4_s, br_tgt_s, addr_s;
    logic [31:0] sr_s, cause_s, cp0_rd_s, wd_s, npc_s, wdata_s;
    logic [15:0] half_s;
    logic [7:0]  byte_s;
    logic [3:0]  be_s;
    logic        we_s, ri_s, mtc0_s, eret_s, adel_s, ades_s, irq_s, exc_s;

    assign op_s       = i_inst_rdata[31:26];
    assign rs_s       = i_inst_rdata[25:21];
    assign rt_s       = i_inst_rdata[20:16];
    assign rd_s       = i_inst_rdata[15:11];
    assign shamt_s    = i_inst_rdata[10:6];
    assign funct_s    = i_inst_rdata[5:0];
    assign rs_val_s   = grf_r[rs_s];
    assign rt_val_s   = grf_r[rt_s];
    assign imm_sext_s = {{16{i_inst_rdata[15]}}, i_inst_rdata[15:0]};
    assign imm_zext_s = {16'h0000, i_inst_rdata[15:0]};
    assign pc4_s      = pc_r + 32'd4;
    assign br_tgt_s   = pc4_s + {imm_sext_s[29:0], 2'b00};
    assign addr_s     = rs_val_s + imm_sext_s;
    assign half_s     = addr_s[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    assign byte_s     = m_data_rdata[{addr_s[1:0], 3'b000} +: 8];

    // Only IP[12] is wired; the rest of Cause.IP reads zero.
    assign ip_s    = {3'b000, interrupt, 2'b00};
    assign sr_s    = {16'h0000, im_r, 8'h00, exl_r, ie_r};
    assign cause_s = {16'h0000, ip_s, 3'b000, exc_code_r, 2'b00};

    // CP0 read mux for mfc0.
    always_comb begin
        cp0_rd_s = 32'h0000_0000;
        case (rd_s)
            5'd12:   cp0_rd_s = sr_s;
            5'd13:   cp0_rd_s = cause_s;
            5'd14:   cp0_rd_s = epc_r;
            default: cp0_rd_s = 32'h0000_0000;
        endcase
    end

    // Decode and execute: GRF write, next PC, store lanes and RI detection.
    always_comb begin
        we_s    = 1'b0;
        wa_s    = rt_s;
        wd_s    = 32'h0000_0000;
        npc_s   = pc4_s;
        be_s    = 4'b0000;
        wdata_s = rt_val_s;
        ri_s    = 1'b0;
        mtc0_s  = 1'b0;
        eret_s  = 1'b0;
        case (op_s)
            6'h00: begin
                wa_s = rd_s;
                case (funct_s)
                    6'h21: begin we_s = 1'b1; wd_s = rs_val_s + rt_val_s; end
                    6'h23: begin we_s = 1'b1; wd_s = rs_val_s - rt_val_s; end
                    6'h24: begin we_s = 1'b1; wd_s = rs_val_s & rt_val_s; end
                    6'h25: begin we_s = 1'b1; wd_s = rs_val_s | rt_val_s; end
                    6'h2a: begin we_s = 1'b1; wd_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)}; end
                    6'h2b: begin we_s = 1'b1; wd_s = {31'd0, rs_val_s < rt_val_s}; end
                    6'h00: begin we_s = 1'b1; wd_s = rt_val_s << shamt_s; end
                    6'h02: begin we_s = 1'b1; wd_s = rt_val_s >> shamt_s; end
                    6'h08: npc_s = rs_val_s;
                    6'h09: begin we_s = 1'b1; wd_s = pc4_s; npc_s = rs_val_s; end
                    default: ri_s = 1'b1;
                endcase
            end
            6'h09: begin we_s = 1'b1; wd_s = rs_val_s + imm_sext_s; end
            6'h0c: begin we_s = 1'b1; wd_s = rs_val_s & imm_zext_s; end
            6'h0d: begin we_s = 1'b1; wd_s = rs_val_s | imm_zext_s; end
            6'h0f: begin we_s = 1'b1; wd_s = {i_inst_rdata[15:0], 16'h0000}; end
            6'h04: begin
                if (rs_val_s == rt_val_s) npc_s = br_tgt_s;
                else                      npc_s = pc4_s;
            end
            6'h05: begin
                if (rs_val_s != rt_val_s) npc_s = br_tgt_s;
                else                      npc_s = pc4_s;
            end
            6'h02: npc_s = {pc4_s[31:28], i_inst_rdata[25:0], 2'b00};
            6'h03: begin
                npc_s = {pc4_s[31:28], i_inst_rdata[25:0], 2'b00};
                we_s  = 1'b1;
                wa_s  = 5'd31;
                wd_s  = pc4_s;
            end
            6'h23: begin we_s = 1'b1; wd_s = m_data_rdata; end
            6'h21: begin we_s = 1'b1; wd_s = {{16{half_s[15]}}, half_s}; end
            6'h20: begin we_s = 1'b1; wd_s = {{24{byte_s[7]}}, byte_s}; end
            6'h2b: be_s = 4'b1111;
            6'h29: begin
                be_s    = addr_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{rt_val_s[15:0]}};
            end
            6'h28: begin
                be_s    = 4'b0001 << addr_s[1:0];
                wdata_s = {4{rt_val_s[7:0]}};
            end
            6'h10: begin
                if (rs_s == 5'h00) begin
                    we_s = 1'b1;
                    wd_s = cp0_rd_s;
                end else if (rs_s == 5'h04) begin
                    mtc0_s = 1'b1;
                end else if (rs_s == 5'h10 && funct_s == 6'h18) begin
                    eret_s = 1'b1;
                    npc_s  = epc_r;
                end else begin
                    ri_s = 1'b1;
                end
            end
            default: ri_s = 1'b1;
        endcase
    end

`ifdef MIPS_CPU_ADDR_EXC_EN
    // Misaligned fetch, word and half accesses trap instead of being masked.
    always_comb begin
        adel_s = (pc_r[1:0] != 2'b00);
        ades_s = 1'b0;
        case (op_s)
            6'h23:   adel_s = adel_s | (addr_s[1:0] != 2'b00);
            6'h21:   adel_s = adel_s | addr_s[0];
            6'h2b:   ades_s = (addr_s[1:0] != 2'b00);
            6'h29:   ades_s = addr_s[0];
            default: ades_s = 1'b0;
        endcase
    end
`else
    assign adel_s = 1'b0;
    assign ades_s = 1'b0;
`endif

    assign irq_s = ie_r & ~exl_r & (|(ip_s & im_r));
    assign exc_s = irq_s | ri_s | adel_s | ades_s;

    // Exception priority: interrupt, RI, AdEL, AdES.
    always_comb begin
        if (irq_s)       exc_code_s = 5'd0;
        else if (ri_s)   exc_code_s = 5'd10;
        else if (adel_s) exc_code_s = 5'd4;
        else             exc_code_s = 5'd5;
    end

    assign macroscopic_pc = pc_r;
    assign i_inst_addr    = pc_r;
    assign m_inst_addr    = pc_r;
    assign w_inst_addr    = pc_r;
    assign m_data_addr    = addr_s;
    assign m_data_wdata   = wdata_s;
    assign m_data_byteen  = (reset || exc_s) ? 4'b0000 : be_s;
    assign w_grf_we       = we_s & ~exc_s & ~reset;
    assign w_grf_addr     = wa_s;
    assign w_grf_wdata    = wd_s;

    // Architectural state commit: PC, GRF and CP0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= 32'h0000_3000;
            epc_r      <= 32'h0000_0000;
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            exc_code_r <= 5'd0;
            for (int i = 0; i < 32; i++) grf_r[i] <= 32'h0000_0000;
        end else if (exc_s) begin
            pc_r       <= 32'h0000_4180;
            epc_r      <= pc_r;
            exl_r      <= 1'b1;
            exc_code_r <= exc_code_s;
        end else begin
            pc_r <= npc_s;
            if (we_s && wa_s != 5'd0) grf_r[wa_s] <= wd_s;
            if (eret_s) exl_r <= 1'b0;
            if (mtc0_s) begin
                case (rd_s)
                    5'd12: begin
                        im_r  <= rt_val_s[15:10];
                        exl_r <= rt_val_s[1];
                        ie_r  <= rt_val_s[0];
                    end
                    5'd14:   epc_r <= rt_val_s;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed program with hand-computed GRF/store trace; a monitor pops the expected queue
// whenever the CPU presents a register write or a store.
module tb_mips_cpu;
    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
    logic [31:0] m_data_wdata, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    typedef struct {
        logic        is_mem;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] imem [0:8191];
    logic [31:0] dmem [0:1023];

    always #5 clk = ~clk;

    mips_cpu dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr)
    );

    assign i_inst_rdata = imem[i_inst_addr[14:2]];
    assign m_data_rdata = dmem[m_data_addr[11:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) dmem[m_data_addr[11:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction
    function automatic logic [31:0] mfc0(input logic [4:0] rt, input logic [4:0] rd);
        return {6'h10, 5'h00, rt, rd, 11'h000};
    endfunction
    function automatic logic [31:0] mtc0(input logic [4:0] rt, input logic [4:0] rd);
        return {6'h10, 5'h04, rt, rd, 11'h000};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem[addr[14:2]] = word;
    endtask
    task automatic exp_w(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] data);
        exp_q.push_back('{1'b0, pc, {27'd0, r}, data, 4'b0000});
    endtask
    task automatic exp_m(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data);
        exp_q.push_back('{1'b1, pc, addr, data, be});
    endtask
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask
    task automatic wait_pc(input logic [31:0] target);
        bit found = 1'b0;
        for (int n = 0; n < 500 && !found; n++) begin
            @(negedge clk);
            if (macroscopic_pc == target) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_pc: pc %h never reached, last pc %h", target, macroscopic_pc);
        end
    endtask

    // Monitor: compare each GRF write / store against the head of the expected queue.
    always @(negedge clk) begin
        #2;
        if (!reset && w_grf_we && w_grf_addr != 5'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grf_write: got pc=%h r%0d=%h, required no write", w_inst_addr, w_grf_addr, w_grf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_mem || mon_e.pc !== w_inst_addr || mon_e.addr !== {27'd0, w_grf_addr}
                    || mon_e.data !== w_grf_wdata) begin
                    errors++;
                    $display("FAIL grf_write: got pc=%h r%0d=%h, required pc=%h addr=%h data=%h store=%0d",
                             w_inst_addr, w_grf_addr, w_grf_wdata, mon_e.pc, mon_e.addr, mon_e.data, mon_e.is_mem);
                end
            end
        end
        if (!reset && m_data_byteen != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store: got pc=%h addr=%h be=%b data=%h, required no store",
                         m_inst_addr, m_data_addr, m_data_byteen, m_data_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_mem || mon_e.pc !== m_inst_addr || mon_e.addr !== m_data_addr
                    || mon_e.be !== m_data_byteen || mon_e.data !== m_data_wdata) begin
                    errors++;
                    $display("FAIL store: got pc=%h addr=%h be=%b data=%h, required pc=%h addr=%h be=%b data=%h",
                             m_inst_addr, m_data_addr, m_data_byteen, m_data_wdata,
                             mon_e.pc, mon_e.addr, mon_e.be, mon_e.data);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        interrupt = 1'b0;
        for (int i = 0; i < 8192; i++) imem[i] = 32'h0000_0000;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0000_0000;

        put(32'h3000, ei(6'h0d, 5'd0, 5'd1, 16'h1234));     // ori $1,0x1234
        put(32'h3004, ei(6'h0d, 5'd0, 5'd2, 16'h00AB));     // ori $2,0xAB
        put(32'h3008, ei(6'h28, 5'd0, 5'd2, 16'h0003));     // sb $2,3($0)
        put(32'h300C, ei(6'h20, 5'd0, 5'd3, 16'h0003));     // lb $3,3($0)
        put(32'h3010, ei(6'h04, 5'd0, 5'd0, 16'h0002));     // beq $0,$0,+2
        put(32'h3014, ei(6'h0d, 5'd0, 5'd4, 16'hDEAD));
        put(32'h3018, ei(6'h0d, 5'd0, 5'd4, 16'hDEAD));
        put(32'h301C, ej(6'h03, 32'h3080));                 // jal 0x3080
        put(32'h3020, ei(6'h2b, 5'd0, 5'd1, 16'h0010));     // sw $1,0x10($0)
        put(32'h3024, ei(6'h23, 5'd0, 5'd6, 16'h0010));     // lw $6,0x10($0)
        put(32'h3028, mfc0(5'd7, 5'd12));
        put(32'h302C, ei(6'h0d, 5'd0, 5'd8, 16'h1000));
        put(32'h3030, mtc0(5'd8, 5'd12));                   // SR: IE=0
        put(32'h3034, mfc0(5'd9, 5'd13));
        put(32'h3038, er(5'd2, 5'd1, 5'd10, 5'd0, 6'h23));  // subu
        put(32'h303C, er(5'd10, 5'd1, 5'd11, 5'd0, 6'h2a)); // slt
        put(32'h3040, 32'hFC00_0000);                        // reserved opcode
        put(32'h3044, er(5'd10, 5'd1, 5'd12, 5'd0, 6'h2b)); // sltu
        put(32'h3048, ei(6'h0f, 5'd0, 5'd13, 16'h8000));    // lui
        put(32'h304C, er(5'd0, 5'd13, 5'd14, 5'd4, 6'h02)); // srl
        put(32'h3050, er(5'd0, 5'd1, 5'd15, 5'd4, 6'h00));  // sll
        put(32'h3054, ei(6'h05, 5'd0, 5'd0, 16'h0004));     // bne not taken
        put(32'h3058, ei(6'h29, 5'd0, 5'd10, 16'h0006));    // sh $10,6($0)
        put(32'h305C, ei(6'h21, 5'd0, 5'd16, 16'h0006));    // lh $16,6($0)
        put(32'h3060, ei(6'h0c, 5'd10, 5'd17, 16'hFF00));   // andi
        put(32'h3064, ej(6'h02, 32'h3070));                 // j 0x3070
        put(32'h3068, ei(6'h0d, 5'd0, 5'd25, 16'hBAD0));
        put(32'h306C, ei(6'h0d, 5'd0, 5'd25, 16'hBAD0));
        put(32'h3070, ei(6'h09, 5'd0, 5'd20, 16'hFFFF));    // addiu -1
        put(32'h3074, ei(6'h0d, 5'd0, 5'd21, 16'h3090));
        put(32'h3078, er(5'd21, 5'd0, 5'd22, 5'd0, 6'h09)); // jalr $22,$21
        put(32'h3080, ei(6'h0d, 5'd0, 5'd5, 16'h1001));
        put(32'h3084, mtc0(5'd5, 5'd12));                   // SR: IM[12], IE
        put(32'h3088, er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));  // jr $31
        put(32'h3090, er(5'd10, 5'd20, 5'd23, 5'd0, 6'h24)); // and
        put(32'h3094, er(5'd1, 5'd13, 5'd24, 5'd0, 6'h25));  // or
        put(32'h3098, ej(6'h02, 32'h3098));                 // park
        put(32'h4180, mfc0(5'd2, 5'd13));
        put(32'h4184, mfc0(5'd3, 5'd14));
        put(32'h4188, mfc0(5'd4, 5'd12));
        put(32'h418C, ei(6'h04, 5'd2, 5'd0, 16'h0002));     // interrupt: retry, else skip
        put(32'h4190, ei(6'h09, 5'd3, 5'd3, 16'h0004));
        put(32'h4194, mtc0(5'd3, 5'd14));
        put(32'h4198, 32'h4200_0018);                       // eret

        exp_w(32'h3000, 5'd1, 32'h0000_1234);
        exp_w(32'h3004, 5'd2, 32'h0000_00AB);
        exp_m(32'h3008, 32'h0000_0003, 4'b1000, 32'hABAB_ABAB);
        exp_w(32'h300C, 5'd3, 32'hFFFF_FFAB);
        exp_w(32'h301C, 5'd31, 32'h0000_3020);
        exp_w(32'h3080, 5'd5, 32'h0000_1001);
        exp_w(32'h4180, 5'd2, 32'h0000_0000);
        exp_w(32'h4184, 5'd3, 32'h0000_3020);
        exp_w(32'h4188, 5'd4, 32'h0000_1003);
        exp_m(32'h3020, 32'h0000_0010, 4'b1111, 32'h0000_1234);
        exp_w(32'h3024, 5'd6, 32'h0000_1234);
        exp_w(32'h3028, 5'd7, 32'h0000_1001);
        exp_w(32'h302C, 5'd8, 32'h0000_1000);
        exp_w(32'h3034, 5'd9, 32'h0000_1000);
        exp_w(32'h3038, 5'd10, 32'hFFFF_EDCC);
        exp_w(32'h303C, 5'd11, 32'h0000_0001);
        exp_w(32'h4180, 5'd2, 32'h0000_0028);
        exp_w(32'h4184, 5'd3, 32'h0000_3040);
        exp_w(32'h4188, 5'd4, 32'h0000_1002);
        exp_w(32'h4190, 5'd3, 32'h0000_3044);
        exp_w(32'h3044, 5'd12, 32'h0000_0000);
        exp_w(32'h3048, 5'd13, 32'h8000_0000);
        exp_w(32'h304C, 5'd14, 32'h0800_0000);
        exp_w(32'h3050, 5'd15, 32'h0001_2340);
        exp_m(32'h3058, 32'h0000_0006, 4'b1100, 32'hEDCC_EDCC);
        exp_w(32'h305C, 5'd16, 32'hFFFF_EDCC);
        exp_w(32'h3060, 5'd17, 32'h0000_ED00);
        exp_w(32'h3070, 5'd20, 32'hFFFF_FFFF);
        exp_w(32'h3074, 5'd21, 32'h0000_3090);
        exp_w(32'h3078, 5'd22, 32'h0000_307C);
        exp_w(32'h3090, 5'd23, 32'hFFFF_EDCC);
        exp_w(32'h3094, 5'd24, 32'h8000_1234);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", macroscopic_pc, 32'h0000_3000);
        chk("reset_grf_we", {31'd0, w_grf_we}, 32'd0);
        chk("reset_byteen", {28'd0, m_data_byteen}, 32'd0);
        reset = 1'b0;

        wait_pc(32'h3020);
        interrupt = 1'b1;
        @(posedge clk);
        #1 interrupt = 1'b0;
        @(negedge clk);
        chk("irq_redirect_pc", macroscopic_pc, 32'h0000_4180);

        wait_pc(32'h3034);
        interrupt = 1'b1;
        wait_pc(32'h303C);
        interrupt = 1'b0;

        wait_pc(32'h3040);
        @(negedge clk);
        chk("ri_redirect_pc", macroscopic_pc, 32'h0000_4180);

        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("pending_expected", exp_q.size(), 32'd0);
        chk("final_pc", macroscopic_pc, 32'h0000_3098);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
